// File: rtl/led_status_ctrl.sv
// Shares the four board LEDs between heartbeat, activity flash and error blink-code.
// Priority is error > activity > heartbeat; led/mode are registered views of the state.
module led_status_ctrl #(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned ACT_TICKS = 2,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       act_pulse,
  input  logic       err_valid,
  input  logic [3:0] err_code,
  input  logic       err_clear,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       err_active
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ACT_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_TICKS);
  localparam logic [AW-1:0] A_ONE    = AW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
  localparam logic [GW-1:0] G_ONE    = GW'(1);

  localparam logic [1:0] M_HB  = 2'd0;
  localparam logic [1:0] M_ACT = 2'd1;
  localparam logic [1:0] M_ERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ERR_ON,
    ERR_OFF,
    ERR_GAP
  } err_state_t;

  err_state_t      state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [3:0]      blinks_q, blinks_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      hb_cnt;
  logic [AW-1:0]   act_cnt;
  logic [3:0]      led_d;
  logic [1:0]      mode_d;
  logic            tick;
  logic            accept;

  assign tick = (tick_cnt == TICK_MAX);

  // A clear in the same cycle blocks latching a new error.
  assign accept = (state_q == IDLE) && err_valid
                  && (err_code != 4'd0) && !err_clear;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    blinks_d = blinks_q;
    gap_d    = gap_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          code_d   = err_code;
          blinks_d = err_code;
          state_d  = ERR_ON;
        end
      end
      ERR_ON: begin
        if (tick) begin
          blinks_d = blinks_q - 4'd1;
          if (blinks_q == 4'd1) begin
            state_d = ERR_GAP;
            gap_d   = '0;
          end else begin
            state_d = ERR_OFF;
          end
        end
      end
      ERR_OFF: begin
        if (tick) state_d = ERR_ON;
      end
      ERR_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            blinks_d = code_q;
            state_d  = ERR_ON;
          end else begin
            gap_d = gap_q + G_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_clear && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    led_d  = hb_cnt;
    mode_d = M_HB;
    if (state_q != IDLE) begin
      mode_d = M_ERR;
      unique case (state_q)
        ERR_ON:  led_d = 4'b1111;
        ERR_GAP: led_d = code_q;
        default: led_d = 4'b0000;
      endcase
    end else if (act_cnt != '0) begin
      mode_d = M_ACT;
      led_d  = {hb_cnt[3:1], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= '0;
      blinks_q   <= '0;
      gap_q      <= '0;
      tick_cnt   <= '0;
      hb_cnt     <= '0;
      act_cnt    <= '0;
      err_active <= 1'b0;
      led        <= '0;
      mode       <= M_HB;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      blinks_q   <= blinks_d;
      gap_q      <= gap_d;
      err_active <= (state_d != IDLE);
      led        <= led_d;
      mode       <= mode_d;
      // Restart the tick phase so the first blink is a full tick long.
      if (accept || tick) tick_cnt <= '0;
      else                tick_cnt <= tick_cnt + T_ONE;
      if (tick && !err_active) hb_cnt <= hb_cnt + 4'd1;
      if (act_pulse && !err_active)   act_cnt <= ACT_LOAD;
      else if (tick && act_cnt != '0) act_cnt <= act_cnt - A_ONE;
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: tick-arithmetic reference model,
// directed scenarios followed by randomized traffic.
module tb_led_status_ctrl;

  localparam int TD = 4;
  localparam int AT = 2;
  localparam int GT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       act_pulse;
  logic       err_valid;
  logic [3:0] err_code;
  logic       err_clear;
  logic [3:0] led;
  logic [1:0] mode;
  logic       err_active;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .TICK_DIV (TD),
    .ACT_TICKS(AT),
    .GAP_TICKS(GT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .act_pulse (act_pulse),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_clear (err_clear),
    .led       (led),
    .mode      (mode),
    .err_active(err_active)
  );

  typedef struct packed {
    logic [3:0] led;
    logic [1:0] mode;
    logic       ea;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Model state: cycle index, tick phase origin, counters, latched error.
  int m_c     = 0;
  int m_base  = 0;
  int m_hb    = 0;
  int m_act   = 0;
  int m_code  = 0;
  int m_ebase = 0;
  bit m_err   = 0;

  task automatic model_step();
    exp_t e;
    int   k;
    int   p;
    bit   tk;
    e = '0;
    if (rst) begin
      m_base = m_c + 1;
      m_hb   = 0;
      m_act  = 0;
      m_err  = 0;
      m_code = 0;
    end else begin
      tk = ((m_c - m_base) % TD) == TD - 1;
      if (m_err) begin
        p = 2 * m_code - 1 + GT;
        k = ((m_c - m_ebase) / TD) % p;
        e.mode = 2'd2;
        if (k >= 2 * m_code - 1) e.led = 4'(m_code);
        else if (k % 2 == 0)     e.led = 4'hF;
        else                     e.led = 4'h0;
      end else if (m_act != 0) begin
        e.mode = 2'd1;
        e.led  = 4'(m_hb | 1);
      end else begin
        e.mode = 2'd0;
        e.led  = 4'(m_hb);
      end
      if (tk && !m_err) m_hb = (m_hb + 1) % 16;
      if (act_pulse && !m_err)  m_act = AT;
      else if (tk && m_act > 0) m_act = m_act - 1;
      if (m_err && err_clear) begin
        m_err = 0;
      end else if (!m_err && err_valid && err_code != 0 && !err_clear) begin
        m_err   = 1;
        m_code  = int'(err_code);
        m_ebase = m_c + 1;
        m_base  = m_c + 1;
      end
      e.ea = m_err;
    end
    m_c++;
    sbq.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit a, input bit v,
                     input logic [3:0] c, input bit cl);
    rst       = r;
    act_pulse = a;
    err_valid = v;
    err_code  = c;
    err_clear = cl;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'd0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led t=%0t got %h want %h", $time, led, e.led);
        end
        checks++;
        if (mode !== e.mode) begin
          errors++;
          $display("FAIL mode t=%0t got %0d want %0d", $time, mode, e.mode);
        end
        checks++;
        if (err_active !== e.ea) begin
          errors++;
          $display("FAIL err_active t=%0t got %b want %b",
                   $time, err_active, e.ea);
        end
      end
    end
  end

  initial begin : driver
    cyc(1, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 4'd0, 0);
    idle(64);
    idle(10);
    cyc(0, 1, 0, 4'd0, 0);
    idle(6);
    cyc(0, 1, 0, 4'd0, 0);
    idle(20);
    cyc(0, 0, 1, 4'd3, 0);
    idle(40);
    cyc(0, 1, 1, 4'd5, 0);
    idle(40);
    cyc(0, 0, 0, 4'd0, 1);
    idle(10);
    cyc(0, 0, 1, 4'd0, 0);
    idle(5);
    cyc(0, 0, 1, 4'd1, 0);
    idle(6);
    cyc(0, 0, 1, 4'd2, 1);
    idle(5);
    cyc(0, 0, 0, 4'd0, 1);
    idle(3);
    cyc(0, 0, 1, 4'd1, 0);
    idle(10);
    cyc(1, 0, 0, 4'd0, 0);
    idle(20);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 999) < 3,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 2,
          4'($urandom_range(0, 15)),
          $urandom_range(0, 199) < 1);
    end
    idle(2);
    #5;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
